// File: rtl/slot_turn_ctrl.sv
// Turn controller for a column-drop board game: moves the column cursor, issues
// drop requests to the board logic, alternates players and halts on game over.
module slot_turn_ctrl #(
  parameter int unsigned NUM_COLS    = 7,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_drop,
  input  logic       drop_ack,
  input  logic       drop_ok,
  input  logic       game_over,
  output logic       drop_req,
  output logic [3:0] drop_col,
  output logic       player,
  output logic [3:0] slot_bcd,
  output logic [3:0] player_bcd,
  output logic       err_full
);

  localparam int unsigned SLOT_W = 4;
  localparam int unsigned WAIT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] ST_SELECT  = 2'd0;
  localparam logic [1:0] ST_REQUEST = 2'd1;
  localparam logic [1:0] ST_HALT    = 2'd2;

  localparam logic [SLOT_W-1:0] SLOT_MAX  = SLOT_W'(NUM_COLS - 1);
  localparam logic [SLOT_W-1:0] BCD_BLANK = 4'hF;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SLOT_W-1:0] drop_col_q, drop_col_d;
  logic              player_q, player_d;
  logic              drop_req_q, drop_req_d;
  logic              err_full_q, err_full_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]        slot_bcd_q, slot_bcd_d;
  logic [3:0]        player_bcd_q, player_bcd_d;
  logic              btn_left_q, btn_right_q, btn_drop_q;

  logic left_rise, right_rise, drop_rise;

  assign left_rise  = btn_left  & ~btn_left_q;
  assign right_rise = btn_right & ~btn_right_q;
  assign drop_rise  = btn_drop  & ~btn_drop_q;

  // Next-state and next-output logic; game_over overrides everything, including an ack.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    drop_col_d = drop_col_q;
    player_d   = player_q;
    drop_req_d = drop_req_q;
    err_full_d = 1'b0;
    wait_d     = wait_q;

    if (game_over) begin
      state_d    = ST_HALT;
      drop_req_d = 1'b0;
    end else begin
      case (state_q)
        ST_SELECT: begin
          if (drop_rise) begin
            drop_col_d = slot_q;
            drop_req_d = 1'b1;
            wait_d     = '0;
            state_d    = ST_REQUEST;
          end else if (left_rise && !right_rise) begin
            slot_d = (slot_q == '0) ? SLOT_MAX : slot_q - SLOT_W'(1);
          end else if (right_rise && !left_rise) begin
            slot_d = (slot_q == SLOT_MAX) ? '0 : slot_q + SLOT_W'(1);
          end
        end

        ST_REQUEST: begin
          if (drop_ack) begin
            drop_req_d = 1'b0;
            state_d    = ST_SELECT;
            if (drop_ok) begin
              player_d = ~player_q;
            end else begin
              err_full_d = 1'b1;
            end
          end else if (wait_q == WAIT_LAST) begin
            // Board never answered: treat it like a refused drop.
            drop_req_d = 1'b0;
            err_full_d = 1'b1;
            wait_d     = '0;
            state_d    = ST_SELECT;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end

        ST_HALT: begin
          state_d = ST_HALT;
        end

        default: begin
          state_d    = ST_SELECT;
          drop_req_d = 1'b0;
        end
      endcase
    end

    slot_bcd_d   = (state_d == ST_HALT) ? BCD_BLANK : slot_d;
    player_bcd_d = {3'b000, player_d};
  end

  // Button history resets high so a button held through reset is not an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SELECT;
      slot_q       <= '0;
      drop_col_q   <= '0;
      player_q     <= 1'b0;
      drop_req_q   <= 1'b0;
      err_full_q   <= 1'b0;
      wait_q       <= '0;
      slot_bcd_q   <= '0;
      player_bcd_q <= '0;
      btn_left_q   <= 1'b1;
      btn_right_q  <= 1'b1;
      btn_drop_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      drop_col_q   <= drop_col_d;
      player_q     <= player_d;
      drop_req_q   <= drop_req_d;
      err_full_q   <= err_full_d;
      wait_q       <= wait_d;
      slot_bcd_q   <= slot_bcd_d;
      player_bcd_q <= player_bcd_d;
      btn_left_q   <= btn_left;
      btn_right_q  <= btn_right;
      btn_drop_q   <= btn_drop;
    end
  end

  assign drop_req   = drop_req_q;
  assign drop_col   = drop_col_q;
  assign player     = player_q;
  assign slot_bcd   = slot_bcd_q;
  assign player_bcd = player_bcd_q;
  assign err_full   = err_full_q;

endmodule

// File: doc/slot_turn_ctrl.md
SLOT_TURN_CTRL -- requirements
Module: slot_turn_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_COLS, default 7, giving the number of board columns (legal 2..10).
REQ-002 The module SHALL have parameter ACK_TIMEOUT, default 255, giving the maximum cycles to wait for drop_ack.
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 btn_left  input  1  debounced, clk-synchronous level; move selection left.
REQ-007 btn_right  input  1  debounced, clk-synchronous level; move selection right.
REQ-008 btn_drop  input  1  debounced, clk-synchronous level; request a drop in the selected column.
REQ-009 drop_ack  input  1  one-cycle pulse from board logic completing a drop request.
REQ-010 drop_ok  input  1  qualified by drop_ack: 1 = piece placed, 0 = column full.
REQ-011 game_over  input  1  level from board logic; win or draw detected.
REQ-012 drop_req  output  1  registered; held high while a drop request is outstanding.
REQ-013 drop_col  output  4  registered column index of the outstanding request.
REQ-014 player  output  1  registered active player, 0 = Blue, 1 = Red.
REQ-015 slot_bcd  output  4  BCD digit for the slot display decoder.
REQ-016 player_bcd  output  4  BCD digit for the player display decoder.
REQ-017 err_full  output  1  one-cycle pulse: drop refused (column full) or timed out.

Function
REQ-018 Button events SHALL be rising edges: btn high this cycle and registered previous value low.
REQ-019 FSM states SHALL be SELECT, REQUEST and HALT.
REQ-020 In SELECT, a left edge SHALL decrement slot, wrapping 0 -> NUM_COLS-1, effective at the same clock edge.
REQ-021 In SELECT, a right edge SHALL increment slot, wrapping NUM_COLS-1 -> 0.
REQ-022 Simultaneous left and right edges SHALL leave slot unchanged.
REQ-023 A drop edge in SELECT SHALL latch drop_col = slot, set drop_req = 1 and enter REQUEST on the next edge; left/right edges in that cycle SHALL be ignored.
REQ-024 In REQUEST all button edges SHALL be ignored; slot and drop_col SHALL hold.
REQ-025 drop_ack with drop_ok = 1 in REQUEST SHALL clear drop_req, toggle player and return to SELECT at that edge.
REQ-026 drop_ack with drop_ok = 0 SHALL clear drop_req, pulse err_full, keep player and return to SELECT.
REQ-027 A wait counter SHALL clear on entering REQUEST; when it reaches ACK_TIMEOUT without drop_ack, the FSM SHALL behave as in REQ-026.
REQ-028 drop_ack outside REQUEST SHALL be ignored.
REQ-029 game_over high in any state SHALL force HALT on the next edge and clear drop_req; this takes priority over drop_ack in the same cycle, and player does not toggle.
REQ-030 HALT SHALL be exited only by rst; all inputs are ignored.
REQ-031 slot_bcd SHALL equal slot in SELECT/REQUEST and 4'hF (blank) in HALT.
REQ-032 player_bcd SHALL equal {3'b000, player} in every state; in HALT it shows the last player to move successfully (the winner).

Reset
REQ-033 rst SHALL asynchronously force state = SELECT, slot = 0, drop_col = 0, player = 0, drop_req = 0, err_full = 0, wait counter = 0.
REQ-034 The previous-value button registers SHALL reset to 1, so a button held through reset release produces no event.
REQ-035 rst asserted during REQUEST SHALL abandon the request with drop_req low immediately.

Verification
REQ-036 From reset, 3 right edges then 5 left edges -> slot_bcd 3 then 5 (wrap through 0, NUM_COLS = 7).
REQ-037 slot = 4, drop edge; ack with drop_ok = 1 two cycles later -> drop_req high exactly 3 cycles, drop_col = 4, player 0 -> 1, player_bcd = 1.
REQ-038 Drop, then ack with drop_ok = 0 -> err_full pulses 1 cycle, player unchanged, FSM back in SELECT.
REQ-039 Drop, no ack for ACK_TIMEOUT cycles -> drop_req falls, err_full pulses, player unchanged; left/right edges during the wait do not change slot.
REQ-040 game_over asserted in the same cycle as drop_ack (ok = 1) -> HALT, slot_bcd = 4'hF, player unchanged; buttons ignored until rst.
REQ-041 btn_right held high across rst release -> slot stays 0; after release and re-press -> slot = 1.
